// File: rtl/icm_buffer_sram_arbiter.sv
// icm_buffer_sram_arbiter
// Gives one of the three ICMBuffer threads (get, set, del) exclusive use of
// the write/address ports of one cache bank: way_0 SRAM, way_1 SRAM and LRU SRAM.
// Arbitration is round-robin. The released bank goes to the next requester
// with no idle cycle in between.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   <x>_req / <x>_done        request (held until granted) / one-cycle release pulse
//   <x>_gnt                   registered grant, at most one high
//   <x>_way_{0,1}_*, <x>_lru_* requester SRAM write/address inputs
//   way_{0,1}_*, lru_*        SRAM write/address ports, driven from the owner's inputs
//   err_hold_timeout          sticky, set when one grant is held MAX_HOLD cycles
module icm_buffer_sram_arbiter #(
  parameter int unsigned CACHE_ENTRY_WIDTH = 256,
  parameter int unsigned CACHE_TAG_WIDTH   = 14,
  parameter int unsigned CACHE_SET_NUM_LOG = 10,
  parameter int unsigned MAX_HOLD          = 64,
  localparam int unsigned W     = CACHE_ENTRY_WIDTH + CACHE_TAG_WIDTH + 1,
  localparam int unsigned AW    = CACHE_SET_NUM_LOG,
  localparam int unsigned HOLDW = $clog2(MAX_HOLD) + 1
) (
  input  logic          clk,
  input  logic          rst,
  // get
  input  logic          get_req,
  input  logic          get_done,
  output logic          get_gnt,
  input  logic          get_way_0_wen,
  input  logic [AW-1:0] get_way_0_addr,
  input  logic [W-1:0]  get_way_0_din,
  input  logic          get_way_1_wen,
  input  logic [AW-1:0] get_way_1_addr,
  input  logic [W-1:0]  get_way_1_din,
  input  logic          get_lru_wen,
  input  logic [AW-1:0] get_lru_addr,
  input  logic          get_lru_din,
  // set
  input  logic          set_req,
  input  logic          set_done,
  output logic          set_gnt,
  input  logic          set_way_0_wen,
  input  logic [AW-1:0] set_way_0_addr,
  input  logic [W-1:0]  set_way_0_din,
  input  logic          set_way_1_wen,
  input  logic [AW-1:0] set_way_1_addr,
  input  logic [W-1:0]  set_way_1_din,
  input  logic          set_lru_wen,
  input  logic [AW-1:0] set_lru_addr,
  input  logic          set_lru_din,
  // del
  input  logic          del_req,
  input  logic          del_done,
  output logic          del_gnt,
  input  logic          del_way_0_wen,
  input  logic [AW-1:0] del_way_0_addr,
  input  logic [W-1:0]  del_way_0_din,
  input  logic          del_way_1_wen,
  input  logic [AW-1:0] del_way_1_addr,
  input  logic [W-1:0]  del_way_1_din,
  input  logic          del_lru_wen,
  input  logic [AW-1:0] del_lru_addr,
  input  logic          del_lru_din,
  // SRAM side
  output logic          way_0_wen,
  output logic [AW-1:0] way_0_addr,
  output logic [W-1:0]  way_0_din,
  output logic          way_1_wen,
  output logic [AW-1:0] way_1_addr,
  output logic [W-1:0]  way_1_din,
  output logic          lru_wen,
  output logic [AW-1:0] lru_addr,
  output logic          lru_din,
  output logic          err_hold_timeout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state;
  logic [1:0]       owner;   // 0=get, 1=set, 2=del
  logic [1:0]       rr_ptr;
  logic [2:0]       gnt;
  logic [HOLDW-1:0] hold_cnt;
  logic             err;

  logic [2:0] req_vec;
  logic [3:0] done_vec;      // padded so a 2-bit index always lands in range
  logic [1:0] owner_inc;
  logic [1:0] rr_pick;
  logic [1:0] rel_pick;
  logic       any_req;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First requester at or after start in cyclic order get->set->del.
  // Scanning from the far end lets the nearest hit win.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] idx;
    res = start;
    for (int k = 2; k >= 0; k--) begin
      idx = start;
      for (int j = 0; j < k; j++) idx = inc3(idx);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] v;
    v = 3'b000;
    unique case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  assign req_vec   = {del_req, set_req, get_req};
  assign done_vec  = {1'b0, del_done, set_done, get_done};
  assign any_req   = |req_vec;
  assign owner_inc = inc3(owner);
  assign rr_pick   = pick(req_vec, rr_ptr);
  // Starting after the owner puts the releasing thread last in line.
  assign rel_pick  = pick(req_vec, owner_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      owner    <= 2'd0;
      rr_ptr   <= 2'd0;
      gnt      <= 3'b000;
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (any_req) begin
            state    <= StBusy;
            owner    <= rr_pick;
            gnt      <= onehot(rr_pick);
            hold_cnt <= '0;
          end
        end
        StBusy: begin
          if (done_vec[owner]) begin
            rr_ptr   <= owner_inc;
            hold_cnt <= '0;
            if (any_req) begin
              owner <= rel_pick;
              gnt   <= onehot(rel_pick);
            end else begin
              state <= StIdle;
              gnt   <= 3'b000;
            end
          end else begin
            if (hold_cnt != HOLDW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
            // Flag in the same edge where the count reaches MAX_HOLD.
            if (hold_cnt >= HOLDW'(MAX_HOLD - 1)) err <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign get_gnt          = gnt[0];
  assign set_gnt          = gnt[1];
  assign del_gnt          = gnt[2];
  assign err_hold_timeout = err;

  // Owner's ports pass straight through; everything is zero with no owner.
  always_comb begin
    way_0_wen  = 1'b0;
    way_0_addr = '0;
    way_0_din  = '0;
    way_1_wen  = 1'b0;
    way_1_addr = '0;
    way_1_din  = '0;
    lru_wen    = 1'b0;
    lru_addr   = '0;
    lru_din    = 1'b0;
    if (state == StBusy) begin
      unique case (owner)
        2'd0: begin
          way_0_wen = get_way_0_wen; way_0_addr = get_way_0_addr; way_0_din = get_way_0_din;
          way_1_wen = get_way_1_wen; way_1_addr = get_way_1_addr; way_1_din = get_way_1_din;
          lru_wen   = get_lru_wen;   lru_addr   = get_lru_addr;   lru_din   = get_lru_din;
        end
        2'd1: begin
          way_0_wen = set_way_0_wen; way_0_addr = set_way_0_addr; way_0_din = set_way_0_din;
          way_1_wen = set_way_1_wen; way_1_addr = set_way_1_addr; way_1_din = set_way_1_din;
          lru_wen   = set_lru_wen;   lru_addr   = set_lru_addr;   lru_din   = set_lru_din;
        end
        2'd2: begin
          way_0_wen = del_way_0_wen; way_0_addr = del_way_0_addr; way_0_din = del_way_0_din;
          way_1_wen = del_way_1_wen; way_1_addr = del_way_1_addr; way_1_din = del_way_1_din;
          lru_wen   = del_lru_wen;   lru_addr   = del_lru_addr;   lru_din   = del_lru_din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icm_buffer_sram_arbiter.sv
// Bench for icm_buffer_sram_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a small behavioural model of the arbiter.
module tb_icm_buffer_sram_arbiter;

  localparam int unsigned EW = 256;
  localparam int unsigned TW = 14;
  localparam int unsigned AW = 10;
  localparam int unsigned MH = 64;
  localparam int unsigned W  = EW + TW + 1;
  localparam int unsigned PW = 3 + 3 * AW + 2 * W + 1;

  logic clk;
  logic rst;
  logic [2:0] req;
  logic [2:0] done;
  logic          w0_wen[3];
  logic [AW-1:0] w0_addr[3];
  logic [W-1:0]  w0_din[3];
  logic          w1_wen[3];
  logic [AW-1:0] w1_addr[3];
  logic [W-1:0]  w1_din[3];
  logic          l_wen[3];
  logic [AW-1:0] l_addr[3];
  logic          l_din[3];

  logic get_gnt, set_gnt, del_gnt;
  logic          way_0_wen, way_1_wen, lru_wen, lru_din, err_hold_timeout;
  logic [AW-1:0] way_0_addr, way_1_addr, lru_addr;
  logic [W-1:0]  way_0_din, way_1_din;

  int checks;
  int failures;

  // Model: owner -1 means no grant.
  int m_owner;
  int m_rr;
  int m_hold;
  bit m_err;

  icm_buffer_sram_arbiter #(
    .CACHE_ENTRY_WIDTH(EW), .CACHE_TAG_WIDTH(TW), .CACHE_SET_NUM_LOG(AW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rst(rst),
    .get_req(req[0]), .get_done(done[0]), .get_gnt(get_gnt),
    .get_way_0_wen(w0_wen[0]), .get_way_0_addr(w0_addr[0]), .get_way_0_din(w0_din[0]),
    .get_way_1_wen(w1_wen[0]), .get_way_1_addr(w1_addr[0]), .get_way_1_din(w1_din[0]),
    .get_lru_wen(l_wen[0]), .get_lru_addr(l_addr[0]), .get_lru_din(l_din[0]),
    .set_req(req[1]), .set_done(done[1]), .set_gnt(set_gnt),
    .set_way_0_wen(w0_wen[1]), .set_way_0_addr(w0_addr[1]), .set_way_0_din(w0_din[1]),
    .set_way_1_wen(w1_wen[1]), .set_way_1_addr(w1_addr[1]), .set_way_1_din(w1_din[1]),
    .set_lru_wen(l_wen[1]), .set_lru_addr(l_addr[1]), .set_lru_din(l_din[1]),
    .del_req(req[2]), .del_done(done[2]), .del_gnt(del_gnt),
    .del_way_0_wen(w0_wen[2]), .del_way_0_addr(w0_addr[2]), .del_way_0_din(w0_din[2]),
    .del_way_1_wen(w1_wen[2]), .del_way_1_addr(w1_addr[2]), .del_way_1_din(w1_din[2]),
    .del_lru_wen(l_wen[2]), .del_lru_addr(l_addr[2]), .del_lru_din(l_din[2]),
    .way_0_wen(way_0_wen), .way_0_addr(way_0_addr), .way_0_din(way_0_din),
    .way_1_wen(way_1_wen), .way_1_addr(way_1_addr), .way_1_din(way_1_din),
    .lru_wen(lru_wen), .lru_addr(lru_addr), .lru_din(lru_din),
    .err_hold_timeout(err_hold_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  function automatic logic [2:0] gnt_vec();
    return {del_gnt, set_gnt, get_gnt};
  endfunction

  function automatic logic [2:0] exp_gnt();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  function automatic logic [PW-1:0] act_path();
    return {way_0_wen, way_0_addr, way_0_din, way_1_wen, way_1_addr, way_1_din,
            lru_wen, lru_addr, lru_din};
  endfunction

  function automatic logic [PW-1:0] exp_path();
    int o;
    if (m_owner < 0) return '0;
    o = m_owner;
    return {w0_wen[o], w0_addr[o], w0_din[o], w1_wen[o], w1_addr[o], w1_din[o],
            l_wen[o], l_addr[o], l_din[o]};
  endfunction

  // First requester at or after 'start' going get -> set -> del -> get.
  function automatic int first_from(int start);
    for (int k = 0; k < 3; k++) if (req[(start + k) % 3]) return (start + k) % 3;
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs present before it.
  function automatic void model_step();
    if (rst) begin
      m_owner = -1; m_rr = 0; m_hold = 0; m_err = 0;
    end else if (m_owner < 0) begin
      m_owner = first_from(m_rr);
      m_hold  = 0;
    end else if (done[m_owner]) begin
      m_rr    = (m_owner + 1) % 3;
      m_owner = first_from(m_rr);
      m_hold  = 0;
    end else begin
      if (m_hold < MH) m_hold++;
      if (m_hold >= MH) m_err = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    req = 3'b000;
    done = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w0_wen[i] = 0; w0_addr[i] = '0; w0_din[i] = '0;
      w1_wen[i] = 0; w1_addr[i] = '0; w1_din[i] = '0;
      l_wen[i] = 0; l_addr[i] = '0; l_din[i] = 0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt_vec() !== 3'b000 || act_path() !== '0 || err_hold_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b err=%b path_nonzero=%b, required gnt=000 err=0 path=0",
               gnt_vec(), err_hold_timeout, |act_path());
    end
    // set owns the bank and is writing way_0 when reset hits mid-cycle.
    req[1] = 1'b1;
    tick();
    w0_wen[1] = 1'b1; w0_addr[1] = 10'h2A;
    #1;
    checks++;
    if (set_gnt !== 1'b1 || way_0_wen !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_write: set_gnt=%b way_0_wen=%b, required 1 1", set_gnt, way_0_wen);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (way_0_wen !== 1'b0 || gnt_vec() !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_write: way_0_wen=%b gnt=%b, required 0 000", way_0_wen, gnt_vec());
    end
    clear_inputs();
    tick();
    rst = 1'b0;
    req[0] = 1'b1;
    tick();
    checks++;
    if (gnt_vec() !== 3'b001) begin
      failures++;
      $display("FAIL reset_first_grant: gnt=%b, required 001", gnt_vec());
    end
  endtask

  task automatic test_single_get();
    do_reset();
    req[0] = 1'b1;
    tick();
    w0_addr[0] = 10'h15;
    #1;
    checks++;
    if (get_gnt !== 1'b1 || way_0_addr !== 10'h15) begin
      failures++;
      $display("FAIL single_get_grant: get_gnt=%b way_0_addr=%h, required 1 015",
               get_gnt, way_0_addr);
    end
    tick();
    req[0] = 1'b0; done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    checks++;
    if (gnt_vec() !== 3'b000 || way_0_addr !== '0) begin
      failures++;
      $display("FAIL single_get_release: gnt=%b way_0_addr=%h, required 000 000",
               gnt_vec(), way_0_addr);
    end
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    do_reset();
    req = 3'b111;
    tick();
    foreach (order[n]) begin
      checks++;
      if (gnt_vec() !== 3'(1 << order[n])) begin
        failures++;
        $display("FAIL round_robin_%0d: gnt=%b, required %b", n, gnt_vec(), 3'(1 << order[n]));
      end
      tick();
      done[order[n]] = 1'b1;
      tick();
      done = 3'b000;
    end
    req = 3'b000;
  endtask

  task automatic test_isolation();
    do_reset();
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    w1_wen[1] = 1'b0; w1_addr[1] = 10'h0C3;
    w1_wen[2] = 1'b1; w1_addr[2] = 10'h3FF; w1_din[2] = rand_w();
    done[2] = 1'b1;
    #1;
    checks++;
    if (way_1_wen !== 1'b0 || way_1_addr !== 10'h0C3) begin
      failures++;
      $display("FAIL isolation_path: way_1_wen=%b way_1_addr=%h, required 0 0c3",
               way_1_wen, way_1_addr);
    end
    tick();
    done[2] = 1'b0;
    checks++;
    if (gnt_vec() !== 3'b010) begin
      failures++;
      $display("FAIL isolation_foreign_done: gnt=%b, required 010", gnt_vec());
    end
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
  endtask

  task automatic test_regrant();
    do_reset();
    req[0] = 1'b1;
    tick();
    repeat (40) tick();
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    checks++;
    if (gnt_vec() !== 3'b001) begin
      failures++;
      $display("FAIL regrant_gnt: gnt=%b, required 001", gnt_vec());
    end
    // 80 held cycles in total; only a restarted hold count keeps the flag low.
    repeat (40) tick();
    checks++;
    if (err_hold_timeout !== 1'b0) begin
      failures++;
      $display("FAIL regrant_hold_restart: err_hold_timeout=%b, required 0", err_hold_timeout);
    end
    done[0] = 1'b1; req[0] = 1'b0;
    tick();
    done[0] = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req[0] = 1'b1;
    tick();
    repeat (MH - 1) tick();
    checks++;
    if (err_hold_timeout !== 1'b0 || get_gnt !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: err=%b gnt=%b, required 0 1", err_hold_timeout, get_gnt);
    end
    tick();
    checks++;
    if (err_hold_timeout !== 1'b1 || get_gnt !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag: err=%b gnt=%b, required 1 1", err_hold_timeout, get_gnt);
    end
    req[0] = 1'b0; done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    tick();
    checks++;
    if (err_hold_timeout !== 1'b1 || gnt_vec() !== 3'b000) begin
      failures++;
      $display("FAIL timeout_sticky: err=%b gnt=%b, required 1 000", err_hold_timeout, gnt_vec());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (err_hold_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset_clear: err=%b, required 0", err_hold_timeout);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int errs_here;
    errs_here = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      done = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (m_owner == i) begin
          if ($urandom_range(3) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
        end
        w0_wen[i] = 1'($urandom); w0_addr[i] = AW'($urandom); w0_din[i] = rand_w();
        w1_wen[i] = 1'($urandom); w1_addr[i] = AW'($urandom); w1_din[i] = rand_w();
        l_wen[i] = 1'($urandom); l_addr[i] = AW'($urandom); l_din[i] = 1'($urandom);
      end
      if (m_owner >= 0 && $urandom_range(2) == 0) done[m_owner] = 1'b1;
      if ($urandom_range(7) == 0) done[$urandom_range(2)] = 1'b1;
      #1;
      checks++;
      if (gnt_vec() !== exp_gnt() || err_hold_timeout !== m_err) begin
        failures++;
        errs_here++;
        if (errs_here < 10)
          $display("FAIL random_gnt cyc %0d: gnt=%b err=%b, required %b %b",
                   cyc, gnt_vec(), err_hold_timeout, exp_gnt(), m_err);
      end
      checks++;
      if (act_path() !== exp_path()) begin
        failures++;
        errs_here++;
        if (errs_here < 10)
          $display("FAIL random_path cyc %0d: got %h, required %h", cyc, act_path(), exp_path());
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_owner = -1; m_rr = 0; m_hold = 0; m_err = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_get();
    test_round_robin();
    test_isolation();
    test_regrant();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a scenario stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icm_buffer_sram_arbiter.md
# icm_buffer_sram_arbiter

Shares one ICM cache bank between the three ICMBuffer threads: get (lookup), set (fill/update) and del (invalidate). The bank is way_0 SRAM, way_1 SRAM and the LRU SRAM. The block grants exclusive ownership of all three SRAM write/address ports to one thread at a time, using round-robin arbitration. It sits between the thread modules and the SRAM instances inside ICMBuffer.

## Interface
Parameters:
- CACHE_ENTRY_WIDTH, 256, data bits per way entry.
- CACHE_TAG_WIDTH, 14, tag bits per way entry.
- CACHE_SET_NUM_LOG, 10, SRAM address width.
- MAX_HOLD, 64, grant-hold cycles before timeout is flagged.
- Derived: W = CACHE_ENTRY_WIDTH + CACHE_TAG_WIDTH + 1 (valid bit at MSB).

Ports (x ∈ {get, set, del}; each requester family is three separate ports):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- x_req  in  1  requester x wants the bank; held high until granted.
- x_done  in  1  one-cycle pulse from the owner releasing the bank; ignored unless x_gnt=1.
- x_gnt  out  1  registered; requester x owns the bank.
- x_way_0_wen / x_way_1_wen / x_lru_wen  in  1  requester write enables.
- x_way_0_addr / x_way_1_addr / x_lru_addr  in  CACHE_SET_NUM_LOG  requester addresses.
- x_way_0_din / x_way_1_din  in  W  requester write data.
- x_lru_din  in  1  requester LRU write data.
- way_0_wen, way_1_wen, lru_wen  out  1  to SRAMs.
- way_0_addr, way_1_addr, lru_addr  out  CACHE_SET_NUM_LOG  to SRAMs.
- way_0_din, way_1_din  out  W; lru_din  out  1  to SRAMs.
- err_hold_timeout  out  1  sticky; set when one grant exceeds MAX_HOLD cycles.
- SRAM dout buses are not routed through this block; they fan out directly to all three threads.

## Operation
- States: IDLE, BUSY. Registers: owner (2b one-hot-of-3 or index), rr_ptr (index 0=get, 1=set, 2=del), hold_cnt (saturating, log2(MAX_HOLD)+1 bits).
- IDLE: if any x_req, pick the first requester at or after rr_ptr in the cyclic order get→set→del→get. Next cycle: x_gnt=1, state=BUSY, hold_cnt=0.
- BUSY: SRAM outputs equal the owner's x_* inputs combinationally. Outputs are forced to 0 when no owner, so a non-owner can never write.
- BUSY and owner x_done=1:
  - rr_ptr := owner+1 (mod 3).
  - If any other requester has req=1, grant it next cycle directly (back-to-back, no bubble), choosing from the requesters after the owner in cyclic order. State stays BUSY.
  - The releasing requester's own req is considered only if no other req is high; it is then regranted next cycle.
  - If no req is high: next cycle all gnt=0, state=IDLE.
- x_done from a non-owner: ignored. x_req dropping while granted: grant is kept until done.
- hold_cnt increments every BUSY cycle without done. When hold_cnt reaches MAX_HOLD, set err_hold_timeout; it holds until rst. The grant is not revoked.
- Reset (also mid-transaction): all gnt=0, all SRAM outputs 0, state=IDLE, rr_ptr=0, hold_cnt=0, err_hold_timeout=0. A write in flight is dropped at assertion.

## Timing
- Grant latency: req sampled high in IDLE → gnt high on the next rising edge (1 cycle).
- Requester drives its addr/wen in any cycle where gnt=1. SRAM read data appears 1 cycle after the address, so a get lookup holds the grant for at least 2 cycles.
- Release: done in cycle N → old gnt low in N+1; new gnt (if any) high in N+1. Exactly one gnt is high at any time (one-hot or zero).
- Simultaneous req from all three with rr_ptr=0 and repeated done → grant order get, set, del, get…
- Outputs are registered (gnt) or a combinational mux on registered owner; there is no path from x_req to SRAM outputs.

## Test plan
- Reset: rst=1 mid-BUSY with set owner writing way_0_wen=1 → same cycle way_0_wen=0 and all gnt=0. After release: first get_req granted 1 cycle later.
- Single get: get_req at cycle 0 → get_gnt at 1; get_way_0_addr=0x15 at 1 → way_0_addr=0x15. done at 2 → get_gnt=0 at 3, state IDLE.
- Round robin: get/set/del req all held high, each owner pulses done after 2 grant cycles → gnt sequence get, set, del, get with no idle cycles between.
- Isolation: set owns; del drives del_way_1_wen=1, addr=0x3FF → way_1_wen stays set's value (0). del_done pulse ignored.
- Regrant: only get_req high, get pulses done → get_gnt stays high next cycle, hold_cnt restarts at 0.
- Timeout: MAX_HOLD=64, owner never pulses done → err_hold_timeout=1 at 64th BUSY cycle, stays 1 after later done until rst.
